pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RV32I pipeline (IF, DEC, EXE, MEM, WB). It merges the branch unit's request bundle, instruction/data memory handshakes and load-use holds into per-stage register enables, flush/bubble strobes and the PC-source select. It sits beside the datapath, between `branching` and the PC and pipeline registers, and owns every stall and flush decision.

---
 rtl/core_types_pkg.sv | 38 +++
 rtl/ctrl_perf_counters.sv | 33 +++
 rtl/pipeline_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared pipeline types: branch request bundle, PC-source select and controller state.
// Latency: none (type and constant definitions only).
// Backpressure: none (no handshaking here).
package core_types_pkg;

   localparam int XLEN = 32;

   // Request bundle produced by the branch unit in EXE/DEC
   typedef struct packed {
      logic            flush;      // EXE mispredict, redirect from EXE
      logic            hold;       // load-use hazard detected in DEC
      logic            bypass;     // forwarding select, consumed by the EXE mux
      logic            branch;     // DEC-resolved redirect
      logic [XLEN-1:0] PCnext;     // redirect target
      logic [XLEN-1:0] PCcurrent;  // PC of the requesting instruction
   } branching_out_t;

   typedef enum logic [1:0] {
      PC_SEQ  = 2'd0,
      PC_DEC  = 2'd1,
      PC_EXE  = 2'd2,
      PC_HOLD = 2'd3
   } pc_sel_t;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2,
      FLUSH      = 2'd3
   } ctrl_state_t;

   // Redirect address is only meaningful for the two redirect sources; zero otherwise
   function automatic logic [XLEN-1:0] redirectTarget(input pc_sel_t sel,
                                                      input logic [XLEN-1:0] pcNext);
      return ((sel == PC_DEC) || (sel == PC_EXE)) ? pcNext : '0;
   endfunction

endpackage

// File: rtl/ctrl_perf_counters.sv
// Saturating stall and flush event counters for the pipeline controller.
// Latency: count visible one cycle after the increment strobe.
// Backpressure: none; counters stick at all-ones instead of wrapping.
module ctrl_perf_counters #(
   parameter int PERF_W = 32
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic              stallInc,
   input  logic              flushInc,
   output logic [PERF_W-1:0] stallCount,
   output logic [PERF_W-1:0] flushCount
);

   // Count cycles with a frozen PC, saturating at all-ones
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         stallCount <= '0;
      end else if (stallInc && (stallCount != '1)) begin
         stallCount <= stallCount + PERF_W'(1);
      end
   end

   // Count EXE redirects, saturating at all-ones
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         flushCount <= '0;
      end else if (flushInc && (flushCount != '1)) begin
         flushCount <= flushCount + PERF_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: per-stage enables, flush/bubble strobes and PC select.
// Latency: enables, strobes, pcSel, pcTarget are combinational (0 cycles); state is registered.
// Backpressure: data-memory wait freezes all stages; fetch wait and load-use hold freeze PC and IF/DEC.
module pipeline_ctrl
   import core_types_pkg::*;
#(
   parameter int HOLD_CYCLES = 1,
   parameter int MEM_TIMEOUT = 255,
   parameter int PERF_W      = 32
) (
   input  logic              Clock,
   input  logic              nReset,
   input  branching_out_t    br,
   input  logic              imemReady,
   input  logic              dmemReq,
   input  logic              dmemReady,
   output logic              enPC,
   output logic              enIFDEC,
   output logic              enDECEXE,
   output logic              enEXEMEM,
   output logic              enMEMWB,
   output logic              flushIFDEC,
   output logic              bubbleDECEXE,
   output pc_sel_t           pcSel,
   output logic [XLEN-1:0]   pcTarget,
   output logic              memTimeout,
   output logic [PERF_W-1:0] stallCount,
   output logic [PERF_W-1:0] flushCount,
   output ctrl_state_t       state
);

   localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
   localparam logic [2:0]        HOLD_LOAD = 3'(HOLD_CYCLES - 1);

   logic [2:0]        holdCnt;
   logic              holdMask;
   logic [WAIT_W-1:0] waitCnt;

   ctrl_state_t       stateNext;
   logic [2:0]        holdCntNext;
   logic              holdMaskNext;
   logic [WAIT_W-1:0] waitCntNext;
   logic              memTimeoutNext;

   logic              enFront;     // PC and IF/DEC
   logic              enBack;      // DEC/EXE, EXE/MEM, MEM/WB
   logic              flushInc;
   logic              dataStall;
   logic              inRun;
   logic              unusedBr;

   assign dataStall = dmemReq && !dmemReady;
   assign inRun     = (state == RUN);

   // Forwarding select and the requester's PC are consumed elsewhere in the datapath
   assign unusedBr  = ^{br.bypass, br.PCcurrent};

   // Priority resolution of stall/redirect requests and next-state computation
   always_comb begin
      enFront        = 1'b0;
      enBack         = 1'b0;
      flushIFDEC     = 1'b0;
      bubbleDECEXE   = 1'b0;
      pcSel          = PC_HOLD;
      flushInc       = 1'b0;
      stateNext      = state;
      holdCntNext    = holdCnt;
      holdMaskNext   = holdMask;
      waitCntNext    = waitCnt;
      memTimeoutNext = memTimeout;

      if (!nReset) begin
         // everything stays frozen with PC held while reset is asserted
      end else if (dataStall) begin
         // Whole pipe frozen; branch requests are re-presented once EXE moves again
         stateNext = MEM_WAIT;
         if (waitCnt != WAIT_MAX) begin
            waitCntNext = waitCnt + WAIT_W'(1);
         end
         if (waitCntNext == WAIT_MAX) begin
            memTimeoutNext = 1'b1;
         end
      end else begin
         waitCntNext = '0;
         stateNext   = RUN;
         // A hold mask only survives until one RUN cycle has actually advanced
         if (inRun) begin
            holdMaskNext = 1'b0;
         end

         if (br.flush) begin
            enFront      = 1'b1;
            enBack       = 1'b1;
            flushIFDEC   = 1'b1;
            bubbleDECEXE = 1'b1;
            pcSel        = PC_EXE;
            flushInc     = 1'b1;
            stateNext    = FLUSH;
         end else if (inRun && br.branch) begin
            enFront    = 1'b1;
            enBack     = 1'b1;
            flushIFDEC = 1'b1;
            pcSel      = PC_DEC;
         end else if (inRun && br.hold && !holdMask) begin
            enBack       = 1'b1;
            bubbleDECEXE = 1'b1;
            holdCntNext  = HOLD_LOAD;
            if (HOLD_CYCLES == 1) begin
               holdMaskNext = 1'b1;
            end else begin
               stateNext = LOAD_STALL;
            end
         end else if (state == LOAD_STALL) begin
            enBack       = 1'b1;
            bubbleDECEXE = 1'b1;
            if (holdCnt <= 3'd1) begin
               holdCntNext  = '0;
               holdMaskNext = 1'b1;
            end else begin
               holdCntNext = holdCnt - 3'd1;
               stateNext   = LOAD_STALL;
            end
         end else if (!imemReady) begin
            enBack       = 1'b1;
            bubbleDECEXE = 1'b1;
         end else begin
            enFront = 1'b1;
            enBack  = 1'b1;
            pcSel   = PC_SEQ;
         end
      end
   end

   assign enPC     = enFront;
   assign enIFDEC  = enFront;
   assign enDECEXE = enBack;
   assign enEXEMEM = enBack;
   assign enMEMWB  = enBack;
   assign pcTarget = redirectTarget(pcSel, br.PCnext);

   // Controller FSM state, hold counter/mask, memory wait counter and sticky timeout
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state      <= RUN;
         holdCnt    <= '0;
         holdMask   <= 1'b0;
         waitCnt    <= '0;
         memTimeout <= 1'b0;
      end else begin
         state      <= stateNext;
         holdCnt    <= holdCntNext;
         holdMask   <= holdMaskNext;
         waitCnt    <= waitCntNext;
         memTimeout <= memTimeoutNext;
      end
   end

   ctrl_perf_counters #(
      .PERF_W (PERF_W)
   ) uPerf (
      .Clock      (Clock),
      .nReset     (nReset),
      .stallInc   (~enFront),
      .flushInc   (flushInc),
      .stallCount (stallCount),
      .flushCount (flushCount)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios followed by random traffic.
// Expected responses come from a behavioural model and are checked mid-cycle by a monitor.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_pipeline_ctrl;
   import core_types_pkg::*;

   localparam int HOLD = 2;
   localparam int TMO  = 255;
   localparam int PW   = 32;

   logic           Clock;
   logic           nReset;
   branching_out_t br;
   logic           imemReady, dmemReq, dmemReady;
   logic           enPC, enIFDEC, enDECEXE, enEXEMEM, enMEMWB;
   logic           flushIFDEC, bubbleDECEXE;
   pc_sel_t        pcSel;
   logic [31:0]    pcTarget;
   logic           memTimeout;
   logic [PW-1:0]  stallCount, flushCount;
   ctrl_state_t    state;

   pipeline_ctrl #(
      .HOLD_CYCLES (HOLD),
      .MEM_TIMEOUT (TMO),
      .PERF_W      (PW)
   ) dut (
      .Clock        (Clock),
      .nReset       (nReset),
      .br           (br),
      .imemReady    (imemReady),
      .dmemReq      (dmemReq),
      .dmemReady    (dmemReady),
      .enPC         (enPC),
      .enIFDEC      (enIFDEC),
      .enDECEXE     (enDECEXE),
      .enEXEMEM     (enEXEMEM),
      .enMEMWB      (enMEMWB),
      .flushIFDEC   (flushIFDEC),
      .bubbleDECEXE (bubbleDECEXE),
      .pcSel        (pcSel),
      .pcTarget     (pcTarget),
      .memTimeout   (memTimeout),
      .stallCount   (stallCount),
      .flushCount   (flushCount),
      .state        (state)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct packed {
      logic        enPC, enIFDEC, enDECEXE, enEXEMEM, enMEMWB;
      logic        flushIFDEC, bubbleDECEXE;
      logic [1:0]  pcSel;
      logic [31:0] pcTarget;
      logic        memTimeout;
      logic [31:0] stallCount, flushCount;
      logic [1:0]  state;
   } obs_t;

   obs_t expQ[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Behavioural model: bubbles still owed, one-shot hold mask, consecutive memory
   // wait cycles, whether the previous cycle was an EXE redirect, and event totals.
   int     mHoldLeft;
   bit     mMask;
   int     mWait;
   bit     mTimeout;
   bit     mShadow;
   longint mStalls, mFlushes;

   function automatic logic [31:0] sat32(input longint v);
      return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   task automatic modelCycle(output obs_t e);
      bit run, newMask, nextShadow;
      e = '0;
      if (!nReset) begin
         mHoldLeft = 0; mMask = 0; mWait = 0; mTimeout = 0; mShadow = 0;
         mStalls = 0; mFlushes = 0;
         e.pcSel = PC_HOLD;
         e.state = RUN;
         return;
      end
      e.stallCount = sat32(mStalls);
      e.flushCount = sat32(mFlushes);
      e.memTimeout = mTimeout;
      if (mWait > 0)          e.state = MEM_WAIT;
      else if (mShadow)       e.state = FLUSH;
      else if (mHoldLeft > 0) e.state = LOAD_STALL;
      else                    e.state = RUN;
      run = (mWait == 0) && !mShadow && (mHoldLeft == 0);

      if (dmemReq && !dmemReady) begin
         e.pcSel = PC_HOLD;
         mStalls++;
         if (mWait < TMO) mWait++;
         if (mWait >= TMO) mTimeout = 1;
         mShadow = 0;
         mHoldLeft = 0;
         return;
      end

      mWait = 0;
      newMask = run ? 1'b0 : mMask;
      nextShadow = 0;
      if (br.flush) begin
         {e.enPC, e.enIFDEC, e.enDECEXE, e.enEXEMEM, e.enMEMWB} = 5'b11111;
         e.flushIFDEC = 1; e.bubbleDECEXE = 1;
         e.pcSel = PC_EXE; e.pcTarget = br.PCnext;
         mFlushes++;
         nextShadow = 1;
         mHoldLeft = 0;
      end else if (run && br.branch) begin
         {e.enPC, e.enIFDEC, e.enDECEXE, e.enEXEMEM, e.enMEMWB} = 5'b11111;
         e.flushIFDEC = 1;
         e.pcSel = PC_DEC; e.pcTarget = br.PCnext;
      end else if (run && br.hold && !mMask) begin
         {e.enDECEXE, e.enEXEMEM, e.enMEMWB} = 3'b111;
         e.bubbleDECEXE = 1; e.pcSel = PC_HOLD;
         mHoldLeft = HOLD - 1;
         if (mHoldLeft == 0) newMask = 1;
      end else if (mHoldLeft > 0) begin
         {e.enDECEXE, e.enEXEMEM, e.enMEMWB} = 3'b111;
         e.bubbleDECEXE = 1; e.pcSel = PC_HOLD;
         mHoldLeft--;
         if (mHoldLeft == 0) newMask = 1;
      end else if (!imemReady) begin
         {e.enDECEXE, e.enEXEMEM, e.enMEMWB} = 3'b111;
         e.bubbleDECEXE = 1; e.pcSel = PC_HOLD;
      end else begin
         {e.enPC, e.enIFDEC, e.enDECEXE, e.enEXEMEM, e.enMEMWB} = 5'b11111;
         e.pcSel = PC_SEQ;
      end
      if (!e.enPC) mStalls++;
      mMask = newMask;
      mShadow = nextShadow;
   endtask

   // Drive one cycle of stimulus and queue the response the model expects for it
   task automatic applyVec(input bit rst, input bit fl, input bit ho, input bit bra,
                           input logic [31:0] pcn, input bit imr, input bit dreq,
                           input bit drdy);
      obs_t e;
      @(posedge Clock);
      #1;
      nReset       = !rst;
      br.flush     = fl;
      br.hold      = ho;
      br.branch    = bra;
      br.bypass    = 1'($urandom_range(0, 1));
      br.PCnext    = pcn;
      br.PCcurrent = $urandom;
      imemReady    = imr;
      dmemReq      = dreq;
      dmemReady    = drdy;
      modelCycle(e);
      expQ.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyVec(0, 0, 0, 0, 32'h0, 1, 0, 0);
   endtask

   // Monitor: compare the DUT against the oldest queued expectation each mid-cycle
   initial begin
      obs_t e, a;
      forever begin
         @(negedge Clock);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            a.enPC = enPC; a.enIFDEC = enIFDEC; a.enDECEXE = enDECEXE;
            a.enEXEMEM = enEXEMEM; a.enMEMWB = enMEMWB;
            a.flushIFDEC = flushIFDEC; a.bubbleDECEXE = bubbleDECEXE;
            a.pcSel = pcSel; a.pcTarget = pcTarget; a.memTimeout = memTimeout;
            a.stallCount = stallCount; a.flushCount = flushCount; a.state = state;
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL vec%0d t=%0t: got en=%b%b%b%b%b fl=%b bub=%b sel=%0d tgt=%h to=%b st=%0d sc=%0d fc=%0d | want en=%b%b%b%b%b fl=%b bub=%b sel=%0d tgt=%h to=%b st=%0d sc=%0d fc=%0d",
                        vectors, $time,
                        a.enPC, a.enIFDEC, a.enDECEXE, a.enEXEMEM, a.enMEMWB, a.flushIFDEC,
                        a.bubbleDECEXE, a.pcSel, a.pcTarget, a.memTimeout, a.state,
                        a.stallCount, a.flushCount,
                        e.enPC, e.enIFDEC, e.enDECEXE, e.enEXEMEM, e.enMEMWB, e.flushIFDEC,
                        e.bubbleDECEXE, e.pcSel, e.pcTarget, e.memTimeout, e.state,
                        e.stallCount, e.flushCount);
            end
         end
      end
   end

   // Stimulus: directed hazard scenarios, then random traffic
   initial begin
      bit rst, fl, ho, bra, imr, dreq, drdy;
      nReset = 1'b0;
      br = '0;
      imemReady = 1'b1;
      dmemReq = 1'b0;
      dmemReady = 1'b0;

      applyVec(1, 0, 0, 0, 32'h0, 1, 0, 0);
      applyVec(1, 0, 0, 0, 32'h0, 1, 0, 0);
      idle(3);

      // reset while the memory wait counter sits at 10
      for (int i = 0; i < 10; i++) applyVec(0, 0, 0, 0, 32'h0, 1, 1, 0);
      applyVec(1, 1, 1, 1, 32'h55, 1, 1, 0);
      applyVec(1, 0, 0, 0, 32'h0, 1, 1, 0);
      idle(2);

      // load-use hold held high across three cycles
      for (int i = 0; i < 3; i++) applyVec(0, 0, 1, 0, 32'h0, 1, 0, 0);
      idle(2);

      // EXE redirect with coincident branch and hold, then a branch in the shadow
      applyVec(0, 1, 1, 1, 32'h0000_0100, 1, 0, 0);
      applyVec(0, 0, 0, 1, 32'h0000_0200, 1, 0, 0);
      idle(2);

      // EXE redirect presented during a data-memory wait
      for (int i = 0; i < 3; i++) applyVec(0, 1, 0, 0, 32'h0000_0300, 1, 1, 0);
      applyVec(0, 1, 0, 0, 32'h0000_0300, 1, 1, 1);
      idle(2);

      // memory timeout, sticky after ready returns
      for (int i = 0; i < 256; i++) applyVec(0, 0, 0, 0, 32'h0, 1, 1, 0);
      applyVec(0, 0, 0, 0, 32'h0, 1, 1, 1);
      idle(3);

      // DEC redirect while fetch is not ready
      applyVec(0, 0, 0, 1, 32'h0000_0040, 0, 0, 0);
      idle(2);

      // random traffic
      applyVec(1, 0, 0, 0, 32'h0, 1, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 299) == 0);
         fl   = ($urandom_range(0, 9) == 0);
         ho   = ($urandom_range(0, 3) == 0);
         bra  = ($urandom_range(0, 5) == 0);
         imr  = ($urandom_range(0, 99) < 85);
         dreq = ($urandom_range(0, 99) < 30);
         drdy = ($urandom_range(0, 99) < 60);
         applyVec(rst, fl, ho, bra, $urandom, imr, dreq, drdy);
      end

      // let the monitor drain the queue, bounded
      for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge Clock);
      if (expQ.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
